// File: rtl/mem_responder.sv
// mem_responder: 256x8 single-port memory slave with a fixed number of wait
// states before a one-cycle acknowledge, plus a program-load write port.
// Optional feature: define MEM_WP_EN to write-protect addresses 0..ROM_TOP
// against CPU writes (rejected writes still ack and pulse o_err).
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [7:0]  ROM_TOP     = 8'h7F
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  input  logic       i_we,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_ack,
  output logic       o_busy,
  input  logic       i_load_en,
  input  logic [7:0] i_load_addr,
  input  logic [7:0] i_load_data,
  output logic       o_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

`ifdef MEM_WP_EN
  localparam bit WP_ON = 1'b1;
`else
  localparam bit WP_ON = 1'b0;
`endif

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t     state;
  logic [3:0] cnt;
  logic       lat_we;
  logic [7:0] lat_addr;
  logic [7:0] lat_wdata;
  logic [7:0] mem [256];

  // Without MEM_WP_EN this folds to constant 0, so o_err is a register stuck at 0.
  function automatic logic wp_hit(input logic [7:0] a);
    return WP_ON && (a <= ROM_TOP);
  endfunction

  // Access sequencer: latches the request, counts wait states, issues ack/err/rdata.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      o_rdata   <= '0;
      o_ack     <= 1'b0;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_ack <= 1'b0;
      o_err <= 1'b0;
      case (state)
        S_IDLE: begin
          // A simultaneous load takes the cycle; the request is retried next cycle.
          if (i_req && !i_load_en) begin
            lat_we    <= i_we;
            lat_addr  <= i_addr;
            lat_wdata <= i_wdata;
            o_busy    <= 1'b1;
            if (WAIT_CYCLES > 0) begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end else begin
              // Zero wait states: ack cycle follows directly, so use live inputs.
              state <= S_ACK;
              o_ack <= 1'b1;
              o_err <= i_we && wp_hit(i_addr);
              if (!i_we) o_rdata <= mem[i_addr];
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state <= S_ACK;
            o_ack <= 1'b1;
            o_err <= lat_we && wp_hit(lat_addr);
            if (!lat_we) o_rdata <= mem[lat_addr];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Storage: program loads in IDLE, CPU writes commit on the edge leaving ACK.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state == S_IDLE && i_load_en) begin
        mem[i_load_addr] <= i_load_data;
      end else if (state == S_ACK && lat_we && !wp_hit(lat_addr)) begin
        mem[lat_addr] <= lat_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances (0, 1 and 15 wait states)
// driven by directed tables, hand-written corner sequences and random traffic
// checked against an array-based reference model.
module tb_mem_responder;

`ifdef MEM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic       clk;
  logic [2:0] rst, req, we, load_en;
  logic [7:0] addr [3];
  logic [7:0] wdata [3];
  logic [7:0] load_addr [3];
  logic [7:0] load_data [3];
  logic [7:0] rdata [3];
  logic [2:0] ack, busy, err;

  int n_chk  = 0;
  int n_fail = 0;
  bit force_junk = 1'b0;

  // Reference model: plain memory image plus "has been written" flags.
  logic [7:0] mdl [3][256];
  bit         known [3][256];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .WAIT_CYCLES((g == 0) ? 0 : (g == 1) ? 1 : 15),
      .ROM_TOP    (8'h7F)
    ) dut (
      .i_clk      (clk),
      .i_rst      (rst[g]),
      .i_req      (req[g]),
      .i_we       (we[g]),
      .i_addr     (addr[g]),
      .i_wdata    (wdata[g]),
      .o_rdata    (rdata[g]),
      .o_ack      (ack[g]),
      .o_busy     (busy[g]),
      .i_load_en  (load_en[g]),
      .i_load_addr(load_addr[g]),
      .i_load_data(load_data[g]),
      .o_err      (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int unsigned wc(input int k);
    return (k == 0) ? 0 : (k == 1) ? 1 : 15;
  endfunction

  function automatic bit prot(input logic [7:0] a);
    return WP && (a <= 8'h7F);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic idle_in(input int k);
    req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    load_en[k] = 1'b0; load_addr[k] = '0; load_data[k] = '0;
  endtask

  task automatic junk_in(input int k);
    req[k]   = 1'($urandom);
    we[k]    = 1'($urandom);
    addr[k]  = 8'($urandom);
    wdata[k] = 8'($urandom);
    if (force_junk) begin
      load_en[k] = 1'b1; load_addr[k] = 8'h40; load_data[k] = 8'hFF;
    end else begin
      load_en[k] = 1'($urandom); load_addr[k] = 8'($urandom); load_data[k] = 8'($urandom);
    end
  endtask

  task automatic do_load(input int k, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    idle_in(k);
    load_en[k] = 1'b1; load_addr[k] = a; load_data[k] = d;
    @(negedge clk);
    load_en[k] = 1'b0;
    chk("load_busy", busy[k], 0);
    chk("load_err", err[k], 0);
    mdl[k][a] = d;
    known[k][a] = 1'b1;
  endtask

  // One CPU access; checks latency, busy window, ack/err pulse and read data.
  task automatic access(input int k, input bit w, input logic [7:0] a, input logic [7:0] d,
                        input bit ck, input logic [7:0] exp);
    int unsigned lat;
    logic [7:0] held;
    lat = wc(k) + 1;
    held = '0;
    @(negedge clk);
    chk("pre_busy", busy[k], 0);
    idle_in(k);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    for (int unsigned c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("acc_busy", busy[k], 1);
      chk("acc_ack", ack[k], (c == lat) ? 1 : 0);
      if (c == lat) begin
        chk("acc_err", err[k], (w && prot(a)) ? 1 : 0);
        if (!w && ck) chk("acc_rdata", rdata[k], exp);
        held = rdata[k];
        idle_in(k);
      end else begin
        chk("wait_err", err[k], 0);
        junk_in(k);
      end
    end
    @(negedge clk);
    chk("post_busy", busy[k], 0);
    chk("post_ack", ack[k], 0);
    chk("post_err", err[k], 0);
    chk("rdata_hold", rdata[k], held);
    if (w && !prot(a)) begin
      mdl[k][a] = d;
      known[k][a] = 1'b1;
    end
  endtask

  typedef struct {
    int         k;
    bit         ld;
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    bit         ck;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [$];
  logic [7:0] pool [16];

  initial begin
    for (int k = 0; k < 3; k++) idle_in(k);
    rst = 3'b111;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_rdata", rdata[k], 0);
      chk("rst_ack", ack[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_err", err[k], 0);
    end
    repeat (2) @(negedge clk);
    rst = 3'b000;

    // Directed table
    tbl.push_back(vec_t'{1, 1'b1, 1'b0, 8'h10, 8'hA5, 1'b0, 8'h00});
    tbl.push_back(vec_t'{1, 1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5});
    tbl.push_back(vec_t'{1, 1'b1, 1'b0, 8'h20, 8'h33, 1'b0, 8'h00});
    tbl.push_back(vec_t'{1, 1'b0, 1'b1, 8'h20, 8'hEE, 1'b0, 8'h00});
    tbl.push_back(vec_t'{1, 1'b0, 1'b0, 8'h20, 8'h00, 1'b1, WP ? 8'h33 : 8'hEE});
    tbl.push_back(vec_t'{1, 1'b0, 1'b1, 8'h80, 8'h5A, 1'b0, 8'h00});
    tbl.push_back(vec_t'{1, 1'b0, 1'b0, 8'h80, 8'h00, 1'b1, 8'h5A});
    tbl.push_back(vec_t'{0, 1'b1, 1'b0, 8'h05, 8'hC3, 1'b0, 8'h00});
    tbl.push_back(vec_t'{0, 1'b0, 1'b0, 8'h05, 8'h00, 1'b1, 8'hC3});
    tbl.push_back(vec_t'{2, 1'b1, 1'b0, 8'hFF, 8'h81, 1'b0, 8'h00});
    tbl.push_back(vec_t'{2, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h81});
    tbl.push_back(vec_t'{2, 1'b0, 1'b1, 8'hFE, 8'h6D, 1'b0, 8'h00});
    tbl.push_back(vec_t'{2, 1'b0, 1'b0, 8'hFE, 8'h00, 1'b1, 8'h6D});
    foreach (tbl[i]) begin
      if (tbl[i].ld) do_load(tbl[i].k, tbl[i].a, tbl[i].d);
      else access(tbl[i].k, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].ck, tbl[i].exp);
    end

    // Back-to-back on zero-wait instance: write then read with req held high
    @(negedge clk);
    idle_in(0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 8'hF0; wdata[0] = 8'h3C;
    @(negedge clk);
    chk("b2b_wr_ack", ack[0], 1);
    chk("b2b_wr_busy", busy[0], 1);
    we[0] = 1'b0;
    @(negedge clk);
    chk("b2b_idle_ack", ack[0], 0);
    chk("b2b_idle_busy", busy[0], 0);
    @(negedge clk);
    chk("b2b_rd_ack", ack[0], 1);
    chk("b2b_rd_data", rdata[0], 8'h3C);
    idle_in(0);
    @(negedge clk);
    chk("b2b_end_busy", busy[0], 0);
    mdl[0][8'hF0] = 8'h3C; known[0][8'hF0] = 1'b1;

    // Load and request together: load wins, request taken the next cycle
    @(negedge clk);
    idle_in(0);
    load_en[0] = 1'b1; load_addr[0] = 8'h44; load_data[0] = 8'h9C;
    req[0] = 1'b1; addr[0] = 8'h44;
    @(negedge clk);
    chk("ldreq_busy", busy[0], 0);
    chk("ldreq_ack", ack[0], 0);
    load_en[0] = 1'b0;
    @(negedge clk);
    chk("ldreq_rd_ack", ack[0], 1);
    chk("ldreq_rd_data", rdata[0], 8'h9C);
    idle_in(0);
    @(negedge clk);
    mdl[0][8'h44] = 8'h9C; known[0][8'h44] = 1'b1;

    // Loads presented while busy are ignored
    do_load(2, 8'h40, 8'h12);
    force_junk = 1'b1;
    access(2, 1'b1, 8'hC1, 8'h77, 1'b0, 8'h00);
    force_junk = 1'b0;
    access(2, 1'b0, 8'h40, 8'h00, 1'b1, 8'h12);

    // Reset during the wait state of a write
    do_load(1, 8'h90, 8'h11);
    @(negedge clk);
    idle_in(1);
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 8'h90; wdata[1] = 8'h55;
    @(negedge clk);
    chk("rstw_busy", busy[1], 1);
    chk("rstw_ack", ack[1], 0);
    idle_in(1);
    #2 rst[1] = 1'b1;
    #1;
    chk("rstw_busy_async", busy[1], 0);
    chk("rstw_ack_async", ack[1], 0);
    chk("rstw_rdata_async", rdata[1], 0);
    @(negedge clk);
    chk("rstw_ack_held", ack[1], 0);
    rst[1] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstw_ack_after", ack[1], 0);
      chk("rstw_busy_after", busy[1], 0);
    end
    access(1, 1'b0, 8'h90, 8'h00, 1'b1, 8'h11);

    // Randomized traffic against the model
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) begin
        pool[i] = 8'($urandom);
        do_load(k, pool[i], 8'($urandom));
      end
      for (int i = 0; i < 30; i++) begin
        int unsigned op;
        logic [7:0] a;
        op = $urandom_range(0, 2);
        a = pool[$urandom_range(0, 15)];
        case (op)
          0: do_load(k, a, 8'($urandom));
          1: access(k, 1'b1, a, 8'($urandom), 1'b0, 8'h00);
          default: access(k, 1'b0, a, 8'h00, known[k][a], mdl[k][a]);
        endcase
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: wait states inserted before acknowledge, legal range 0..15.
REQ-002 SHALL have parameter ROM_TOP, default 8'h7F: highest write-protected address when MEM_WP_EN is defined.
REQ-003 SHALL have i_clk, input, 1: single clock, all state updates on the rising edge.
REQ-004 SHALL have i_rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have i_req, input, 1: access request from the CPU data path.
REQ-006 SHALL have i_we, input, 1: 1 = write, 0 = read; sampled with i_req.
REQ-007 SHALL have i_addr, input, 8: access address.
REQ-008 SHALL have i_wdata, input, 8: write data.
REQ-009 SHALL have o_rdata, output, 8: read data, valid while o_ack = 1.
REQ-010 SHALL have o_ack, output, 1: one-cycle completion strobe for both reads and writes.
REQ-011 SHALL have o_busy, output, 1: high while an accepted access is outstanding.
REQ-012 SHALL have i_load_en, input, 1: program-load write strobe.
REQ-013 SHALL have i_load_addr, input, 8: program-load address.
REQ-014 SHALL have i_load_data, input, 8: program-load data.
REQ-015 SHALL have o_err, output, 1: one-cycle strobe on a rejected write; tied to 0 without MEM_WP_EN.

Function
REQ-016 SHALL contain a 256 x 8 storage array addressed directly by the 8-bit address, with no wrap or decode logic.
REQ-017 SHALL implement FSM states IDLE, WAIT and ACK.
REQ-018 In IDLE, with i_req = 1 and i_load_en = 0, SHALL latch i_we, i_addr and i_wdata at the edge.
REQ-019 On that accept, SHALL go to WAIT with wait counter = WAIT_CYCLES-1 if WAIT_CYCLES > 0, else go directly to ACK.
REQ-020 In WAIT, SHALL decrement the counter each cycle and go to ACK after the cycle in which the counter is 0.
REQ-021 In ACK, SHALL assert o_ack for exactly one cycle and return to IDLE on the next edge.
REQ-022 Read latency SHALL be WAIT_CYCLES+1 cycles from the accepting edge to o_ack high.
REQ-023 On a read, o_rdata SHALL hold mem[latched addr] during ACK, and SHALL hold its last value otherwise.
REQ-024 On a write, the array SHALL be updated at the edge leaving ACK.
REQ-025 o_busy SHALL be 1 in WAIT and ACK and 0 in IDLE.
REQ-026 i_req and i_addr/i_we/i_wdata SHALL be ignored while o_busy = 1; latched values SHALL be used.
REQ-027 If i_req is still 1 in the IDLE cycle after ACK, it SHALL be accepted as a new access (back-to-back).
REQ-028 i_load_en SHALL write i_load_data to mem[i_load_addr] in one cycle, but only in IDLE.
REQ-029 i_load_en SHALL be ignored in WAIT and ACK.
REQ-030 When i_load_en = 1 and i_req = 1 in IDLE, load SHALL win; the request SHALL not be accepted that cycle.
REQ-031 A read of an address written in an earlier completed access SHALL return the new data (no stale read).

Reset
REQ-032 i_rst = 1 SHALL immediately force state IDLE, counter 0, o_rdata 8'h00, o_ack 0, o_busy 0, o_err 0.
REQ-033 Reset mid-access SHALL discard the pending access; a pending write SHALL not modify the array.
REQ-034 Reset SHALL not clear the storage array; contents after power-up are undefined until loaded.

Configuration
REQ-035 With MEM_WP_EN defined, CPU writes to addresses 0..ROM_TOP SHALL leave the array unchanged, still complete with o_ack, and pulse o_err in the ACK cycle.
REQ-036 With MEM_WP_EN defined, reads, loads via i_load_en and writes above ROM_TOP SHALL be unaffected.
REQ-037 Without MEM_WP_EN, all CPU writes SHALL succeed, o_err SHALL be constant 0, and ROM_TOP SHALL be unused.

Verification
REQ-038 WAIT_CYCLES=1: load mem[8'h10]=8'hA5, read 8'h10 -> o_ack high exactly 2 cycles after accept, o_rdata = 8'hA5, o_busy high 2 cycles.
REQ-039 WAIT_CYCLES=0: write 8'h3C to 8'hF0, then read 8'hF0 back-to-back with i_req held high -> each access acks 1 cycle after accept, read returns 8'h3C.
REQ-040 i_rst pulsed during WAIT of a write of 8'h55 to 8'h90 (prior value 8'h11) -> o_ack never asserted, o_busy 0 at once, later read of 8'h90 returns 8'h11.
REQ-041 i_load_en and i_req both high in IDLE -> load performed, request accepted next cycle; i_load_en during WAIT -> array unchanged.
REQ-042 MEM_WP_EN, ROM_TOP=8'h7F: write 8'hEE to 8'h20 -> o_ack and o_err pulse together, mem[8'h20] unchanged; write to 8'h80 -> updated, o_err 0.
REQ-043 WAIT_CYCLES=15: read -> o_ack exactly 16 cycles after accept; new i_req during the wait is ignored.
